// File: rtl/memory_board_ctrl_if.sv
// Sequencer <-> board controller bus: state code and selections in, handshakes
// and the renderer-visible board out.
interface memory_board_ctrl_if;
  logic [3:0]  state;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic        se_eligio_carta;
  logic        cartas_mostradas;
  logic        cartas_ocultas;
  logic        cartas_revueltas;
  logic        cartas_verificadas;
  logic        hubo_pareja;
  logic        carta_randomizada;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [47:0] card_values;

  modport master (
    output state, sel_valid, sel_idx,
    input  se_eligio_carta, cartas_mostradas, cartas_ocultas, cartas_revueltas,
           cartas_verificadas, hubo_pareja, carta_randomizada,
           face_up, matched, card_values
  );

  modport slave (
    input  state, sel_valid, sel_idx,
    output se_eligio_carta, cartas_mostradas, cartas_ocultas, cartas_revueltas,
           cartas_verificadas, hubo_pareja, carta_randomizada,
           face_up, matched, card_values
  );
endinterface

// File: rtl/memory_board_ctrl.sv
// Board-side responder for the memory-game sequencer: owns the 16-card layout and
// answers show/hide/shuffle/verify/random-pick. Optional macro SEED_ENTROPY_EN reseeds the LFSR per game.
module memory_board_ctrl #(
  parameter int unsigned SHOW_CYCLES     = 50000000,
  parameter int unsigned MISMATCH_CYCLES = 25000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  memory_board_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    SQ_INICIO    = 4'd0,
    SQ_SHOW      = 4'd1,
    SQ_HIDE      = 4'd2,
    SQ_SHUFFLE   = 4'd3,
    SQ_TURN      = 4'd5,
    SQ_ONE_CARD  = 4'd6,
    SQ_TWO_CARDS = 4'd7,
    SQ_RANDOM    = 4'd8
  } seq_code_t;

  typedef enum logic [2:0] {
    P_IDLE, P_SHOWING, P_HIDING, P_SHUFFLING, P_WAIT_SEL, P_VERIFY, P_RANDOM, P_DONE_WAIT
  } phase_t;

  phase_t      r_phase;
  logic [3:0]  r_prev_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_face;
  logic [15:0] r_match;
  logic [2:0]  r_vals [16];
  logic [31:0] r_cnt;
  logic [3:0]  r_i;
  logic [3:0]  r_sel1;
  logic [3:0]  r_sel2;
  logic [1:0]  r_nsel;
  logic        r_p_sel, r_p_show, r_p_hide, r_p_shuf, r_p_ver, r_hubo, r_p_rand;

  logic        w_chg;
  logic        w_sel_ok;
  logic        w_any_free;
  logic [3:0]  w_j;
  logic [3:0]  w_pick;
  logic [15:0] w_free;
  logic [15:0] w_lfsr_next;

  assign w_chg       = (bus.state != r_prev_state);
  assign w_j         = r_lfsr[3:0];
  assign w_free      = ~(r_face | r_match);
  assign w_any_free  = |w_free;
  assign w_sel_ok    = bus.sel_valid && w_free[bus.sel_idx] && (r_nsel != 2'd2);
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Scan downward so the nearest free card at or above w_j (mod 16) wins last.
  always_comb begin
    w_pick = w_j;
    for (int unsigned off = 16; off > 0; off--) begin
      if (w_free[w_j + 4'(off - 1)]) w_pick = w_j + 4'(off - 1);
    end
  end

`ifdef SEED_ENTROPY_EN
  logic [15:0] r_free;
  logic [15:0] w_mix;

  assign w_mix = r_lfsr ^ r_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_free <= '0;
    else     r_free <= r_free + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_lfsr <= LFSR_SEED;
    else if (bus.state == SQ_SHOW && r_prev_state == SQ_INICIO)
      r_lfsr <= (w_mix == '0) ? LFSR_SEED : w_mix;
    else
      r_lfsr <= w_lfsr_next;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= w_lfsr_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= P_IDLE;
      r_prev_state <= '0;
      r_face       <= '0;
      r_match      <= '0;
      for (int unsigned k = 0; k < 16; k++) r_vals[k] <= 3'(k >> 1);
      r_cnt        <= '0;
      r_i          <= '0;
      r_sel1       <= '0;
      r_sel2       <= '0;
      r_nsel       <= '0;
      r_p_sel      <= 1'b0;
      r_p_show     <= 1'b0;
      r_p_hide     <= 1'b0;
      r_p_shuf     <= 1'b0;
      r_p_ver      <= 1'b0;
      r_hubo       <= 1'b0;
      r_p_rand     <= 1'b0;
    end else begin
      r_prev_state <= bus.state;
      r_p_sel      <= 1'b0;
      r_p_show     <= 1'b0;
      r_p_hide     <= 1'b0;
      r_p_shuf     <= 1'b0;
      r_p_ver      <= 1'b0;
      r_hubo       <= 1'b0;
      r_p_rand     <= 1'b0;
      // A state change preempts whatever the current phase would have done this cycle.
      if (w_chg) begin
        case (bus.state)
          SQ_INICIO: begin
            r_phase <= P_IDLE;
            r_nsel  <= '0;
          end
          SQ_SHOW: begin
            r_phase <= P_SHOWING;
            r_face  <= '1;
            r_cnt   <= SHOW_CYCLES;
            r_nsel  <= '0;
          end
          SQ_HIDE: begin
            r_phase  <= P_HIDING;
            r_face   <= '0;
            r_match  <= '0;
            r_p_hide <= 1'b1;
            r_nsel   <= '0;
          end
          SQ_SHUFFLE: begin
            r_phase <= P_SHUFFLING;
            r_i     <= 4'd15;
            r_nsel  <= '0;
          end
          SQ_TURN, SQ_ONE_CARD: r_phase <= P_WAIT_SEL;
          SQ_TWO_CARDS: begin
            if (r_nsel == 2'd2 && r_vals[r_sel1] == r_vals[r_sel2]) begin
              r_match[r_sel1] <= 1'b1;
              r_match[r_sel2] <= 1'b1;
              r_p_ver         <= 1'b1;
              r_hubo          <= 1'b1;
              r_nsel          <= '0;
              r_phase         <= P_DONE_WAIT;
            end else begin
              r_cnt   <= MISMATCH_CYCLES;
              r_phase <= P_VERIFY;
            end
          end
          SQ_RANDOM: r_phase <= P_RANDOM;
          default: begin
            r_phase <= P_IDLE;
            r_nsel  <= '0;
          end
        endcase
      end else begin
        case (r_phase)
          P_SHOWING: begin
            if (r_cnt <= 32'd1) begin
              r_p_show <= 1'b1;
              r_phase  <= P_DONE_WAIT;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          P_HIDING: r_phase <= P_DONE_WAIT;
          P_SHUFFLING: begin
            if (w_j <= r_i) begin
              r_vals[r_i] <= r_vals[w_j];
              r_vals[w_j] <= r_vals[r_i];
              if (r_i == 4'd1) begin
                r_p_shuf <= 1'b1;
                r_phase  <= P_DONE_WAIT;
              end else begin
                r_i <= r_i - 4'd1;
              end
            end
          end
          P_WAIT_SEL: begin
            if (w_sel_ok) begin
              r_face[bus.sel_idx] <= 1'b1;
              r_p_sel             <= 1'b1;
              if (r_nsel == 2'd0) r_sel1 <= bus.sel_idx;
              else                r_sel2 <= bus.sel_idx;
              r_nsel <= r_nsel + 2'd1;
            end
          end
          P_VERIFY: begin
            if (r_cnt <= 32'd1) begin
              if (r_nsel != 2'd0) r_face[r_sel1] <= 1'b0;
              if (r_nsel == 2'd2) r_face[r_sel2] <= 1'b0;
              r_p_ver <= 1'b1;
              r_nsel  <= '0;
              r_phase <= P_DONE_WAIT;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          P_RANDOM: begin
            if (r_nsel != 2'd2 && w_any_free) begin
              r_face[w_pick] <= 1'b1;
              if (r_nsel == 2'd0) r_sel1 <= w_pick;
              else                r_sel2 <= w_pick;
              r_nsel <= r_nsel + 2'd1;
            end else begin
              r_p_rand <= 1'b1;
              r_phase  <= P_DONE_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.se_eligio_carta    = r_p_sel;
  assign bus.cartas_mostradas   = r_p_show;
  assign bus.cartas_ocultas     = r_p_hide;
  assign bus.cartas_revueltas   = r_p_shuf;
  assign bus.cartas_verificadas = r_p_ver;
  assign bus.hubo_pareja        = r_hubo;
  assign bus.carta_randomizada  = r_p_rand;
  assign bus.face_up            = r_face;
  assign bus.matched            = r_match;

  for (genvar g = 0; g < 16; g++) begin : g_vals
    assign bus.card_values[3*g +: 3] = r_vals[g];
  end

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Directed bench for memory_board_ctrl: expected board/handshakes are derived from
// the game rules each cycle and compared against the DUT on every falling edge.
module tb_memory_board_ctrl;
  localparam int unsigned SHOW_N       = 4;
  localparam int unsigned MIS_N        = 3;
  localparam logic [15:0] SEED         = 16'hACE1;
  localparam logic [47:0] RESET_LAYOUT = 48'hFF6B646D2240;

  localparam int unsigned PB_SEL = 5, PB_SHOW = 4, PB_HIDE = 3, PB_SHUF = 2, PB_VER = 1, PB_RAND = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  memory_board_ctrl_if bus();

  memory_board_ctrl #(
    .SHOW_CYCLES(SHOW_N),
    .MISMATCH_CYCLES(MIS_N),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_on = 1'b0;
  logic [15:0] exp_face;
  logic [15:0] exp_match;
  logic [47:0] exp_vals;
  logic [5:0]  exp_pulse;
  logic        exp_hubo;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // LFSR value the DUT will consume at the next rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [47:0] init_layout();
    logic [47:0] v;
    v = '0;
    for (int unsigned k = 0; k < 16; k++) v[3*k +: 3] = 3'(k / 2);
    return v;
  endfunction

  function automatic logic [2:0] vget(input logic [47:0] v, input int unsigned k);
    return v[3*k +: 3];
  endfunction

  function automatic int unsigned first_free(input logic [3:0] start, input logic [15:0] busy);
    for (int unsigned o = 0; o < 16; o++) begin
      if (!busy[(int'(start) + o) % 16]) return (int'(start) + o) % 16;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("face_up", 64'(bus.face_up), 64'(exp_face));
      chk("matched", 64'(bus.matched), 64'(exp_match));
      chk("card_values", 64'(bus.card_values), 64'(exp_vals));
      chk("pulses", 64'({bus.se_eligio_carta, bus.cartas_mostradas, bus.cartas_ocultas,
                         bus.cartas_revueltas, bus.cartas_verificadas, bus.carta_randomizada}),
          64'(exp_pulse));
      if (exp_pulse[PB_VER]) chk("hubo_pareja", 64'(bus.hubo_pareja), 64'(exp_hubo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_pulse = '0;
    exp_hubo  = 1'b0;
  endtask

  task automatic set_reset_expect();
    exp_face  = '0;
    exp_match = '0;
    exp_vals  = init_layout();
    exp_pulse = '0;
    exp_hubo  = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.state     = 4'd0;
    bus.sel_valid = 1'b0;
    bus.sel_idx   = 4'd0;
    set_reset_expect();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic select(input int unsigned idx, input logic accept);
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 4'(idx);
    tick();
    if (accept) begin
      exp_face[idx]     = 1'b1;
      exp_pulse[PB_SEL] = 1'b1;
    end
  endtask

  // SHOW, HIDE, then SHUFFLE; optionally slam reset when the shuffle index reaches stop_i.
  task automatic run_prefix(input int unsigned stop_i);
    int unsigned i, j, budget;
    logic [15:0] l;
    logic [2:0]  t;
    logic        done;
    bus.state = 4'd1;
    tick();
    exp_face = '1;
    for (int unsigned c = 1; c < SHOW_N; c++) tick();
    tick();
    exp_pulse[PB_SHOW] = 1'b1;
    bus.state = 4'd2;
    tick();
    exp_face = '0;
    exp_match = '0;
    exp_pulse[PB_HIDE] = 1'b1;
    select(5, 1'b0);
    bus.sel_valid = 1'b0;
    tick();
    bus.state = 4'd3;
    tick();
    i = 15;
    budget = 0;
    done = 1'b0;
    while (budget < 2000 && !done) begin
      if (i == stop_i) begin
        rst = 1'b1;
        set_reset_expect();
        tick();
        chk("mid_reset_layout", 64'(bus.card_values), 64'(RESET_LAYOUT));
        return;
      end
      l = m_lfsr;
      tick();
      budget++;
      j = int'(l[3:0]);
      if (j <= i) begin
        t = exp_vals[3*i +: 3];
        exp_vals[3*i +: 3] = exp_vals[3*j +: 3];
        exp_vals[3*j +: 3] = t;
        if (i == 1) begin
          exp_pulse[PB_SHUF] = 1'b1;
          done = 1'b1;
        end else begin
          i--;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL shuffle_budget: no completion within %0d cycles", budget);
    end
  endtask

  task automatic check_multiset();
    int unsigned cnt [8];
    for (int unsigned v = 0; v < 8; v++) cnt[v] = 0;
    for (int unsigned k = 0; k < 16; k++) cnt[bus.card_values[3*k +: 3]]++;
    for (int unsigned v = 0; v < 8; v++) chk("value_count", 64'(cnt[v]), 64'd2);
  endtask

  task automatic verify_mismatch(input int unsigned c, input int unsigned d, input int unsigned n);
    bus.sel_valid = 1'b0;
    bus.state = 4'd7;
    tick();
    for (int unsigned w = 1; w < MIS_N; w++) tick();
    tick();
    if (n >= 1) exp_face[c] = 1'b0;
    if (n >= 2) exp_face[d] = 1'b0;
    exp_pulse[PB_VER] = 1'b1;
    exp_hubo = 1'b0;
    tick();
  endtask

  task automatic play_turns();
    int unsigned b, c, d, e;
    b = 0;
    for (int unsigned k = 15; k > 0; k--) if (k != 3 && vget(exp_vals, k) == vget(exp_vals, 3)) b = k;
    if (vget(exp_vals, 0) == vget(exp_vals, 3)) b = 0;
    bus.state = 4'd5;
    tick();
    select(3, 1'b1);
    select(3, 1'b0);
    bus.sel_valid = 1'b0;
    tick();
    bus.state = 4'd6;
    tick();
    select(b, 1'b1);
    bus.sel_valid = 1'b0;
    bus.state = 4'd7;
    tick();
    exp_match[3] = 1'b1;
    exp_match[b] = 1'b1;
    exp_pulse[PB_VER] = 1'b1;
    exp_hubo = 1'b1;
    tick();
    chk("matched_pair_bits", 64'({bus.matched[3], bus.matched[b]}), 64'd3);
    c = first_free(4'd0, exp_face | exp_match);
    d = c;
    for (int unsigned k = 15; k > c; k--)
      if (!exp_face[k] && !exp_match[k] && vget(exp_vals, k) != vget(exp_vals, c)) d = k;
    e = 0;
    for (int unsigned k = 15; k > 0; k--) if (!exp_face[k] && !exp_match[k] && k != c && k != d) e = k;
    bus.state = 4'd5;
    tick();
    select(c, 1'b1);
    select(d, 1'b1);
    select(e, 1'b0);
    verify_mismatch(c, d, 2);
  endtask

  task automatic run_random(input int unsigned expect_picks);
    int unsigned filled, k;
    logic [15:0] l;
    logic        done;
    bus.state = 4'd8;
    tick();
    filled = 0;
    done = 1'b0;
    for (int unsigned cyc = 0; cyc < 40 && !done; cyc++) begin
      l = m_lfsr;
      tick();
      if (filled < 2 && (~(exp_face | exp_match)) != 16'h0000) begin
        k = first_free(l[3:0], exp_face | exp_match);
        exp_face[k] = 1'b1;
        filled++;
      end else begin
        exp_pulse[PB_RAND] = 1'b1;
        done = 1'b1;
      end
    end
    chk("random_picks", 64'(filled), 64'(expect_picks));
    chk("random_done", 64'(done), 64'd1);
    tick();
  endtask

  task automatic random_test();
    for (int unsigned p = 0; p < 7; p++) begin
      bus.state = 4'd5;
      tick();
      select(2*p, 1'b1);
      select(2*p + 1, 1'b1);
      bus.sel_valid = 1'b0;
      bus.state = 4'd7;
      tick();
      exp_match[2*p]     = 1'b1;
      exp_match[2*p + 1] = 1'b1;
      exp_pulse[PB_VER]  = 1'b1;
      exp_hubo           = 1'b1;
      tick();
    end
    run_random(2);
    chk("random_face_15_14", 64'(bus.face_up[15:14]), 64'd3);
    bus.state = 4'd7;
    tick();
    exp_match[14] = 1'b1;
    exp_match[15] = 1'b1;
    exp_pulse[PB_VER] = 1'b1;
    exp_hubo = 1'b1;
    tick();
    chk("all_matched", 64'(bus.matched), 64'hFFFF);
    bus.state = 4'd5;
    tick();
    run_random(0);
    verify_mismatch(0, 0, 0);
  endtask

  initial begin
    logic [47:0] layout1;
    do_reset();
    chk_on = 1'b1;
    chk("reset_card_values", 64'(bus.card_values), 64'(RESET_LAYOUT));
    chk("reset_face_up", 64'(bus.face_up), 64'h0);
    run_prefix(0);
    layout1 = exp_vals;
    tick();
    check_multiset();
    do_reset();
    run_prefix(9);
    do_reset();
    run_prefix(0);
    chk("layout_repeat", 64'(bus.card_values), 64'(layout1));
    tick();
    play_turns();
    do_reset();
    random_test();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
